// File: rtl/counter.sv
// Loadable up-counter with asynchronous active-low clear.
// Each rising edge either loads data_in, increments, or holds; load has priority.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;

  // Next-count selection: load beats increment, otherwise hold
  always_comb begin
    count_next_s = count_r;
    if (ld) begin
      count_next_s = data_in;
    end else if (inc) begin
      count_next_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register, cleared immediately whenever rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign q = count_r;

endmodule

// File: tb/tb_counter.sv
// Directed and randomized self-checking bench for counter.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_counter;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       ld;
  logic       inc;
  logic [7:0] q;

  int         checks;
  int         errors;
  logic [7:0] exp_q;

  counter #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .ld      (ld),
    .inc     (inc),
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then compare q after the rising edge
  task automatic step(input string tag, input logic l, input logic i,
                      input logic [7:0] d, input logic [7:0] exp);
    ld      = l;
    inc     = i;
    data_in = d;
    @(negedge clk);
    check(tag, q, exp);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    ld      = 1'b1;
    inc     = 1'b0;
    data_in = 8'hA5;
    exp_q   = 8'h00;

    // Reset held with a pending load
    #2 rst = 1'b0;
    #1 check("reset_async", q, 8'h00);
    @(negedge clk);
    check("reset_hold1", q, 8'h00);
    @(negedge clk);
    check("reset_hold2", q, 8'h00);

    // Release and load, then count
    rst = 1'b1;
    step("load_24", 1'b1, 1'b0, 8'h24, 8'h24);
    step("inc_25", 1'b0, 1'b1, 8'h00, 8'h25);
    step("inc_26", 1'b0, 1'b1, 8'h00, 8'h26);
    step("inc_27", 1'b0, 1'b1, 8'h00, 8'h27);

    // Reset between edges while q holds 37
    step("load_37", 1'b1, 1'b0, 8'h37, 8'h37);
    ld      = 1'b1;
    inc     = 1'b1;
    data_in = 8'h5A;
    #2 rst = 1'b0;
    #1 check("reset_mid", q, 8'h00);
    @(negedge clk);
    check("reset_mid_hold", q, 8'h00);
    rst = 1'b1;

    // Priority and hold
    step("load_10", 1'b1, 1'b0, 8'h10, 8'h10);
    step("prio_81", 1'b1, 1'b1, 8'h81, 8'h81);
    for (int k = 0; k < 4; k++) begin
      step("hold_81", 1'b0, 1'b0, 8'hC3, 8'h81);
    end

    // Wrap-around
    step("load_FE", 1'b1, 1'b0, 8'hFE, 8'hFE);
    step("wrap_FF", 1'b0, 1'b1, 8'h00, 8'hFF);
    step("wrap_00", 1'b0, 1'b1, 8'h00, 8'h00);
    step("wrap_01", 1'b0, 1'b1, 8'h00, 8'h01);

    // Random regression against a reference model
    exp_q = 8'h01;
    for (int k = 0; k < 100; k++) begin
      logic       r_ld;
      logic       r_inc;
      logic [7:0] r_d;
      r_ld  = ($urandom_range(0, 3) == 0);
      r_inc = $urandom_range(0, 1) == 1;
      r_d   = 8'($urandom_range(0, 255));
      if (r_ld) begin
        exp_q = r_d;
      end else if (r_inc) begin
        exp_q = exp_q + 8'd1;
      end else begin
        exp_q = exp_q;
      end
      step("random", r_ld, r_inc, r_d, exp_q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
